// File: rtl/serdes_pkg.sv
// Shared types and sizing helpers for the SERDES link blocks.
package serdes_pkg;

  localparam int DEFAULT_BIT_WIDTH = 32;
  localparam int DEFAULT_N_SAMPLES = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_e;

  // Word index width; never narrower than one bit.
  function automatic int idx_width(input int n_samples);
    return (n_samples > 2) ? $clog2(n_samples) : 1;
  endfunction

endpackage

// File: rtl/deserializer_if.sv
// Narrow word stream in, wide parallel frame out, both val/rdy.
interface deserializer_if
  import serdes_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int N_SAMPLES = DEFAULT_N_SAMPLES
) ();

  logic [BIT_WIDTH-1:0] recv_msg;
  logic                 recv_val;
  logic                 recv_rdy;
  logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES];
  logic                 send_val;
  logic                 send_rdy;

  modport master (
    output recv_msg, recv_val, send_rdy,
    input  recv_rdy, send_msg, send_val
  );

  modport slave (
    input  recv_msg, recv_val, send_rdy,
    output recv_rdy, send_msg, send_val
  );

endinterface

// File: rtl/RegisterV_Reset.sv
// N-bit register with write enable and synchronous active-high clear.
module RegisterV_Reset #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // NOTE: q_d defaults to the held value before the enable test, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  // NOTE: state is written with <= so every flop samples pre-edge values regardless of block ordering.
  // NOTE: these are discrete flops, not a RAM macro, so clearing them on reset is cheap and gives a known all-zero frame.
  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/deserializer_control.sv
// Collect/output FSM, word index counter and per-word write enables.
module deserializer_control
  import serdes_pkg::*;
#(
  parameter int N_SAMPLES = DEFAULT_N_SAMPLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  input  logic                 send_rdy,
  output logic                 recv_rdy,
  output logic                 send_val,
  output logic [N_SAMPLES-1:0] wr_en
);

  localparam int                IDX_W    = idx_width(N_SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             recv_rdy_q, recv_rdy_d;
  logic             send_val_q, send_val_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      // recv_rdy is high throughout COLLECT, so recv_val alone marks a transfer.
      COLLECT: begin
        if (recv_val) begin
          if (idx_q == LAST_IDX) begin
            state_d = OUTPUT;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      OUTPUT: begin
        if (send_rdy) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    // Handshake outputs are decoded from the next state so they leave a flop.
    recv_rdy_d = (state_d == COLLECT);
    send_val_d = (state_d == OUTPUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= COLLECT;
      idx_q      <= '0;
      recv_rdy_q <= 1'b1;
      send_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      recv_rdy_q <= recv_rdy_d;
      send_val_q <= send_val_d;
    end
  end

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < N_SAMPLES; i++) begin
      wr_en[i] = (state_q == COLLECT) && recv_val && (idx_q == IDX_W'(i));
    end
  end

  assign recv_rdy = recv_rdy_q;
  assign send_val = send_val_q;

endmodule

// File: rtl/deserializer.sv
// Assembles N_SAMPLES serial words into one parallel frame; word 0 is the first received.
module deserializer
  import serdes_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int N_SAMPLES = DEFAULT_N_SAMPLES
) (
  input logic           clk,
  input logic           reset,
  deserializer_if.slave io
);

  logic [N_SAMPLES-1:0] wr_en;
  logic                 recv_rdy;
  logic                 send_val;

  deserializer_control #(
    .N_SAMPLES(N_SAMPLES)
  ) u_control (
    .clk      (clk),
    .reset    (reset),
    .recv_val (io.recv_val),
    .send_rdy (io.send_rdy),
    .recv_rdy (recv_rdy),
    .send_val (send_val),
    .wr_en    (wr_en)
  );

  assign io.recv_rdy = recv_rdy;
  assign io.send_val = send_val;

  // Frame output is the raw register array; it is only meaningful while send_val is high.
  for (genvar i = 0; i < N_SAMPLES; i++) begin : g_word
    logic [BIT_WIDTH-1:0] word;

    RegisterV_Reset #(
      .N(BIT_WIDTH)
    ) u_reg (
      .clk   (clk),
      .reset (reset),
      .en    (wr_en[i]),
      .d     (io.recv_msg),
      .q     (word)
    );

    assign io.send_msg[i] = word;
  end

endmodule
